// File: rtl/fetch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_ctrl_pkg
//  Description : Shared state encoding, PC-source select codes and hazard
//                helper functions for the IF/ID front-end control sequencer.
//                The datapath 3:1 PC mux decodes the same PCSRC_* codes.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_ctrl_pkg;

    // Sequencer states; 2'b11 is unused and recovers to BOOT.
    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_WAIT = 2'd2
    } fetch_state_t;

    // PC mux select codes shared with the fetch datapath.
    localparam logic [1:0] PCSRC_PLUS4  = 2'b00;  // sequential PC+4
    localparam logic [1:0] PCSRC_TARGET = 2'b01;  // PCTargetE (JAL / taken branch)
    localparam logic [1:0] PCSRC_JALR   = 2'b10;  // {ALUResultE[31:1],1'b0}

    // Redirect source selection; JALR wins over JAL/branch.
    function automatic logic [1:0] pcsrc_select(
        input logic jalr,
        input logic jump,
        input logic branch,
        input logic taken
    );
        if (jalr) begin
            return PCSRC_JALR;
        end else if (jump | (branch & taken)) begin
            return PCSRC_TARGET;
        end else begin
            return PCSRC_PLUS4;
        end
    endfunction

    // A load in E feeding a source of D; x0 never creates a dependency.
    function automatic logic load_use_hazard(
        input logic       load,
        input logic [4:0] rd,
        input logic [4:0] rs1,
        input logic [4:0] rs2
    );
        return load & (rd != 5'd0) & ((rd == rs1) | (rd == rs2));
    endfunction

endpackage : fetch_ctrl_pkg
`default_nettype wire

// File: rtl/fetch_hazard_sequencer_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Up counter with synchronous clear that pins at all-ones
//                instead of wrapping. AtMax flags the pinned value.
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int W = 16
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         Inc,
    input  logic         Clr,
    output logic [W-1:0] Q,
    output logic         AtMax
);

    logic [W-1:0] r_q;
    logic         w_at_max;

    assign w_at_max = &r_q;

    // Count register: clear has priority, increment holds once all-ones.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_q <= '0;
        end else if (Clr) begin
            r_q <= '0;
        end else if (Inc && !w_at_max) begin
            r_q <= r_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    assign Q     = r_q;
    assign AtMax = w_at_max;

endmodule : sat_counter
`default_nettype wire

// File: rtl/fetch_hazard_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_hazard_sequencer
//  Description : IF/ID front-end control. Holds the pipe for a boot window
//                after reset, bubbles load-use hazards, resolves E-stage
//                redirects, absorbs instruction-memory wait states and raises
//                a sticky fetch-timeout flag. Hazard outputs are combinational
//                from the registered state and the current inputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_hazard_sequencer
    import fetch_ctrl_pkg::*;
#(
    parameter int BOOT_CYCLES = 4,     // 1..255
    parameter int TIMEOUT     = 1024,  // 2..65535
    parameter int CNT_W       = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       RdE,
    input  logic             LoadE,
    input  logic             JumpE,
    input  logic             JalrE,
    input  logic             BranchE,
    input  logic             TakenE,
    input  logic             ImemReady,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             FlushE,
    output logic [1:0]       PCSrcE,
    output logic             Booting,
    output logic             ImemTimeout,
    output logic [CNT_W-1:0] StallCount
);

    localparam int         TO_W      = 16;
    localparam logic [7:0] BOOT_LAST = 8'(BOOT_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    fetch_state_t r_state;
    logic [7:0]   r_boot_cnt;
    logic         r_timeout;

    logic         w_booting;
    logic [1:0]   w_pcsrc;
    logic         w_redirect;
    logic         w_load_use;
    logic         w_stall_f;
    logic         w_stall_d;
    logic         w_flush_d;
    logic         w_flush_e;

    logic         w_to_inc;
    logic         w_to_clr;
    logic [TO_W-1:0] w_to_q;
    logic         w_to_at_max;
    logic         w_to_expired;

    logic         w_sc_inc;
    logic         w_sc_at_max;

    assign w_booting  = (r_state == ST_BOOT);
    assign w_pcsrc    = w_booting ? PCSRC_PLUS4
                                  : pcsrc_select(JalrE, JumpE, BranchE, TakenE);
    assign w_redirect = (w_pcsrc != PCSRC_PLUS4);
    assign w_load_use = load_use_hazard(LoadE, RdE, Rs1D, Rs2D);

    // Hazard priority: boot hold, redirect, imem wait, load-use, free-run.
    always_comb begin
        w_stall_f = 1'b0;
        w_stall_d = 1'b0;
        w_flush_d = 1'b0;
        w_flush_e = 1'b0;
        if (w_booting) begin
            w_stall_f = 1'b1;
            w_stall_d = 1'b1;
            w_flush_d = 1'b1;
            w_flush_e = 1'b1;
        end else if (w_redirect) begin
            // PC takes the target even while imem is stalled.
            w_flush_d = 1'b1;
            w_flush_e = 1'b1;
        end else if (!ImemReady || w_load_use) begin
            w_stall_f = 1'b1;
            w_stall_d = 1'b1;
            w_flush_e = 1'b1;
        end
    end

    // Wait-state counting starts with the first not-ready cycle (the RUN
    // cycle that enters WAIT), so TIMEOUT counts consecutive not-ready cycles.
    assign w_to_inc     = !w_booting && !ImemReady && !w_redirect;
    assign w_to_clr     = w_redirect || ImemReady;
    assign w_to_expired = (w_to_q == TO_LAST) || w_to_at_max;

    sat_counter #(
        .W (TO_W)
    ) u_timeout_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .Inc   (w_to_inc),
        .Clr   (w_to_clr),
        .Q     (w_to_q),
        .AtMax (w_to_at_max)
    );

    // Stall cycles outside the boot window; gating at max keeps it quiet once pinned.
    assign w_sc_inc = !w_booting && w_stall_f && !w_sc_at_max;

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .Inc   (w_sc_inc),
        .Clr   (1'b0),
        .Q     (StallCount),
        .AtMax (w_sc_at_max)
    );

    // Sequencer state, boot window counter and sticky timeout flag.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= ST_BOOT;
            r_boot_cnt <= 8'd0;
            r_timeout  <= 1'b0;
        end else begin
            case (r_state)
                ST_BOOT: begin
                    if (r_boot_cnt == BOOT_LAST) begin
                        r_state <= ST_RUN;
                    end else begin
                        r_boot_cnt <= r_boot_cnt + 8'd1;
                    end
                end
                ST_RUN: begin
                    if (!ImemReady && !w_redirect) begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // A redirect while waiting keeps WAIT; only a ready fetch leaves.
                    if (ImemReady) begin
                        r_state <= ST_RUN;
                    end
                end
                default: begin
                    r_state <= ST_BOOT;
                end
            endcase
            if (w_to_inc && w_to_expired) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign StallF      = w_stall_f;
    assign StallD      = w_stall_d;
    assign FlushD      = w_flush_d;
    assign FlushE      = w_flush_e;
    assign PCSrcE      = w_pcsrc;
    assign Booting     = w_booting;
    assign ImemTimeout = r_timeout;

endmodule : fetch_hazard_sequencer
`default_nettype wire
